// File: rtl/data_memory_pkg.sv
// data_memory_pkg
//   Shared defaults for the data memory slice.
//   DEFAULT_DATA_WIDTH : width of one stored word and of the data ports
//   DEFAULT_ADDR_WIDTH : width of the Address port (a word index)
//   DEFAULT_DEPTH      : number of stored words, must be a power of two
//   INDEX_WIDTH        : number of Address bits that select a word
package data_memory_pkg;

  localparam int DEFAULT_DATA_WIDTH = 64;
  localparam int DEFAULT_ADDR_WIDTH = 64;
  localparam int DEFAULT_DEPTH      = 256;
  localparam int INDEX_WIDTH        = $clog2(DEFAULT_DEPTH);

endpackage : data_memory_pkg

// File: rtl/data_memory_if.sv
// data_memory_if
//   Access bus of the data memory. There is no handshake: every enabled
//   access completes on its clock edge.
//   Address     : word index (upper bits beyond the depth alias)
//   WriteData   : word to store on a write
//   MemoryRead  : read enable, sampled on the falling clock edge
//   MemoryWrite : write enable, sampled on the rising clock edge
//   ReadData    : registered read result
//   Modports: master drives the request, slave (the memory) returns ReadData.
interface data_memory_if
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

  logic [ADDR_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  MemoryRead;
  logic                  MemoryWrite;
  logic [DATA_WIDTH-1:0] ReadData;

  modport master (
    output Address,
    output WriteData,
    output MemoryRead,
    output MemoryWrite,
    input  ReadData
  );

  modport slave (
    input  Address,
    input  WriteData,
    input  MemoryRead,
    input  MemoryWrite,
    output ReadData
  );

endinterface : data_memory_if

// File: rtl/data_memory_bank.sv
// data_memory_bank
//   Word storage with a single rising-edge write port and an asynchronous
//   combinational read of the selected word.
//   Clock       : write clock (rising edge)
//   ResetL      : asynchronous active-low clear of every word
//   writeEnable : store writeData into word writeIndex on the rising edge
//   writeIndex  : word selected for writing
//   writeData   : full word to store (no byte masking)
//   readIndex   : word selected for reading
//   readWord    : current content of word readIndex
//   Every word must clear asynchronously, so the array is built from
//   flops rather than a RAM primitive.
module data_memory_bank
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int INDEX_WIDTH = $clog2(DEPTH)
) (
  input  logic                   Clock,
  input  logic                   ResetL,
  input  logic                   writeEnable,
  input  logic [INDEX_WIDTH-1:0] writeIndex,
  input  logic [DATA_WIDTH-1:0]  writeData,
  input  logic [INDEX_WIDTH-1:0] readIndex,
  output logic [DATA_WIDTH-1:0]  readWord
);

  logic [DATA_WIDTH-1:0] wordReg [DEPTH];

  always_ff @(posedge Clock or negedge ResetL) begin
    if (!ResetL) begin
      for (int i = 0; i < DEPTH; i++) begin
        wordReg[i] <= '0;
      end
    end else if (writeEnable) begin
      wordReg[writeIndex] <= writeData;
    end
  end

  // Read is combinational so that a falling-edge read sees the word written
  // at the preceding rising edge (write-first behaviour comes for free).
  assign readWord = wordReg[readIndex];

endmodule : data_memory_bank

// File: rtl/data_memory.sv
// data_memory
//   Word-addressed data memory. Writes happen on the rising edge, reads are
//   captured into ReadData on the falling edge (half-cycle latency), so a
//   read and write of the same word in one cycle returns the new data.
//   Clock  : single clock; writes on rising edge, reads on falling edge
//   ResetL : asynchronous active-low reset, clears ReadData and all words
//   bus    : data_memory_if slave port (Address, WriteData, MemoryRead,
//            MemoryWrite in; ReadData out)
//   Address bits above the index field are ignored, so addresses alias
//   modulo DEPTH. DEPTH must be a power of two.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic          Clock,
  input  logic          ResetL,
  data_memory_if.slave  bus
);

  localparam int IndexWidth = $clog2(DEPTH);

  logic [IndexWidth-1:0] wordIndex;
  logic [DATA_WIDTH-1:0] readWord;
  logic [DATA_WIDTH-1:0] readDataReg;

  // Word index decode: only the low bits select a word.
  assign wordIndex = bus.Address[IndexWidth-1:0];

  generate
    if (ADDR_WIDTH > IndexWidth) begin : gUpperAddr
      // The upper address bits are deliberately dropped (aliasing).
      logic unusedUpperAddr;
      assign unusedUpperAddr = ^bus.Address[ADDR_WIDTH-1:IndexWidth];
    end
  endgenerate

  data_memory_bank #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH       (DEPTH),
    .INDEX_WIDTH (IndexWidth)
  ) uBank (
    .Clock       (Clock),
    .ResetL      (ResetL),
    .writeEnable (bus.MemoryWrite),
    .writeIndex  (wordIndex),
    .writeData   (bus.WriteData),
    .readIndex   (wordIndex),
    .readWord    (readWord)
  );

  // Falling-edge read register: holds its value when MemoryRead is low.
  always_ff @(negedge Clock or negedge ResetL) begin
    if (!ResetL) begin
      readDataReg <= '0;
    end else if (bus.MemoryRead) begin
      readDataReg <= readWord;
    end
  end

  assign bus.ReadData = readDataReg;

endmodule : data_memory

// File: tb/tb_data_memory.sv
// tb_data_memory
//   Self-checking bench for data_memory: a directed vector table, a reset
//   sequence in the middle of an access, and randomized traffic checked
//   against a plain array model of the memory.
module tb_data_memory;

  localparam int DW    = 64;
  localparam int AW    = 64;
  localparam int DEPTH = 256;

  typedef struct {
    string       name;
    bit          wr;
    bit          rd;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] expRead;
  } vec_t;

  logic Clock;
  logic ResetL;

  data_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  data_memory #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH)
  ) dut (
    .Clock  (Clock),
    .ResetL (ResetL),
    .bus    (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference model: memory contents and the value ReadData should hold.
  logic [63:0] model [DEPTH];
  logic [63:0] expHold;
  int          passCount;
  int          totalCount;
  vec_t        vecs[$];

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    expHold = '0;
  endtask

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    totalCount++;
    if (act === exp) begin
      passCount++;
      $display("ok   %-14s ReadData=%h", name, act);
    end else begin
      $display("FAIL %-14s ReadData=%h expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: drive after the falling edge, let the rising edge write
  // and the falling edge read, then sample shortly after.
  task automatic applyCycle(input bit wr, input bit rd,
                            input logic [63:0] addr, input logic [63:0] wdata);
    int idx;
    bus.MemoryWrite = wr;
    bus.MemoryRead  = rd;
    bus.Address     = addr;
    bus.WriteData   = wdata;
    idx = int'(addr % 64'(DEPTH));
    @(posedge Clock);
    if (wr) model[idx] = wdata;
    @(negedge Clock);
    if (rd) expHold = model[idx];
    #1;
  endtask

  initial begin
    passCount  = 0;
    totalCount = 0;
    ResetL          = 1'b0;
    bus.MemoryWrite = 1'b0;
    bus.MemoryRead  = 1'b0;
    bus.Address     = '0;
    bus.WriteData   = '0;
    modelReset();

    repeat (2) @(negedge Clock);
    #1;
    ResetL = 1'b1;
    check("resetState", bus.ReadData, 64'h0);

    // Directed vectors; expected values are hand-derived.
    vecs.push_back('{"rd00",     0, 1, 64'h00,  64'h0,        64'h0});
    vecs.push_back('{"rdFF",     0, 1, 64'hFF,  64'h0,        64'h0});
    vecs.push_back('{"wr14",     1, 0, 64'h14,  64'h0,        64'h0});
    vecs.push_back('{"wr3c",     1, 0, 64'h3c,  64'hffff0000, 64'h0});
    vecs.push_back('{"wr32",     1, 0, 64'h32,  64'haaaaffff, 64'h0});
    vecs.push_back('{"wr33",     1, 0, 64'h33,  64'h5555ff00, 64'h0});
    vecs.push_back('{"wr0c",     1, 0, 64'h0c,  64'd40,       64'h0});
    vecs.push_back('{"rd14",     0, 1, 64'h14,  64'h0,        64'h0});
    vecs.push_back('{"rd3c",     0, 1, 64'h3c,  64'h0,        64'hffff0000});
    vecs.push_back('{"rd32",     0, 1, 64'h32,  64'h0,        64'haaaaffff});
    vecs.push_back('{"rd33",     0, 1, 64'h33,  64'h0,        64'h5555ff00});
    vecs.push_back('{"rd0c",     0, 1, 64'h0c,  64'h0,        64'd40});
    vecs.push_back('{"holdIdle", 0, 0, 64'h3c,  64'h0,        64'd40});
    vecs.push_back('{"wr20a",    1, 0, 64'h20,  64'h0,        64'd40});
    vecs.push_back('{"wr20b",    1, 0, 64'h20,  64'd16435934, 64'd40});
    vecs.push_back('{"rd20",     0, 1, 64'h20,  64'h0,        64'd16435934});
    vecs.push_back('{"rw05",     1, 1, 64'h05,  64'h1234,     64'h1234});
    vecs.push_back('{"wr0cAgain",1, 0, 64'h0c,  64'd40,       64'h1234});
    vecs.push_back('{"wr10c",    1, 0, 64'h10c, 64'd7,        64'h1234});
    vecs.push_back('{"rd0cAlias",0, 1, 64'h0c,  64'h0,        64'd7});
    vecs.push_back('{"rdHighAls",0, 1, 64'hffff00000000010c, 64'h0, 64'd7});
    vecs.push_back('{"rd05",     0, 1, 64'h05,  64'h0,        64'h1234});

    foreach (vecs[i]) begin
      applyCycle(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata);
      check(vecs[i].name, bus.ReadData, vecs[i].expRead);
    end

    // Randomized traffic on a small address window with random high bits.
    for (int n = 0; n < 300; n++) begin
      logic [63:0] addr;
      logic [63:0] wdata;
      bit          wr;
      bit          rd;
      addr      = {$urandom, $urandom};
      addr[7:0] = 8'($urandom_range(0, 31));
      wdata     = {$urandom, $urandom};
      wr        = 1'($urandom_range(0, 1));
      rd        = 1'($urandom_range(0, 1));
      applyCycle(wr, rd, addr, wdata);
      check("random", bus.ReadData, expHold);
    end

    // Reset between a rising and a falling edge.
    applyCycle(1'b1, 1'b1, 64'h08, 64'd50);
    check("wr08", bus.ReadData, 64'd50);
    bus.MemoryWrite = 1'b0;
    bus.MemoryRead  = 1'b1;
    bus.Address     = 64'h08;
    @(posedge Clock);
    #2;
    ResetL = 1'b0;
    #1;
    check("rstImmediate", bus.ReadData, 64'h0);
    bus.MemoryWrite = 1'b1;
    bus.Address     = 64'h09;
    bus.WriteData   = 64'd99;
    @(negedge Clock);
    #1;
    check("rstNoRead", bus.ReadData, 64'h0);
    @(posedge Clock);
    @(negedge Clock);
    #1;
    modelReset();
    ResetL = 1'b1;
    applyCycle(1'b0, 1'b1, 64'h08, 64'h0);
    check("rd08AfterRst", bus.ReadData, 64'h0);
    applyCycle(1'b0, 1'b1, 64'h09, 64'h0);
    check("rd09NoWrite", bus.ReadData, 64'h0);
    applyCycle(1'b1, 1'b1, 64'h08, 64'd77);
    check("firstEdgeOk", bus.ReadData, 64'd77);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule : tb_data_memory

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter DATA_WIDTH, default 64, width of each stored word and of the data ports.
REQ-002 Parameter ADDR_WIDTH, default 64, width of the Address port.
REQ-003 Parameter DEPTH, default 256, number of stored words; SHALL be a power of two.
REQ-004 Clock  input  1  single clock; all state changes SHALL be edge-triggered on it.
REQ-005 ResetL  input  1  asynchronous, active-low reset.
REQ-006 Address  input  ADDR_WIDTH  word index, not a byte address.
REQ-007 WriteData  input  DATA_WIDTH  data to store.
REQ-008 MemoryRead  input  1  read enable.
REQ-009 MemoryWrite  input  1  write enable.
REQ-010 ReadData  output  DATA_WIDTH  registered read result.

Function
REQ-011 Storage SHALL be DEPTH independent words, each DATA_WIDTH bits wide, selected by Address[log2(DEPTH)-1:0].
- Address bits above that field SHALL be ignored (aliasing).
- Consecutive Address values SHALL be distinct words with no byte overlap (e.g. 0x32 and 0x33 never interfere).
REQ-012 Write: on a Clock rising edge with MemoryWrite=1, the selected word SHALL take WriteData in full.
- No byte masking.
- MemoryWrite=0 SHALL leave memory unchanged.
REQ-013 Read: on a Clock falling edge with MemoryRead=1, ReadData SHALL load the selected word.
- Latency is half a cycle.
- Data SHALL be valid before the next rising edge.
REQ-014 With MemoryRead=0 at a falling edge, ReadData SHALL hold its previous value.
REQ-015 When MemoryRead and MemoryWrite are both 1 for the same address, the falling-edge read SHALL return the data written at the preceding rising edge (write-first).
REQ-016 Rewriting an address SHALL overwrite it; the last write wins.
REQ-017 Unwritten words SHALL read as 0 after reset.
REQ-018 No handshake exists: every enabled access SHALL complete on its edge, and the block SHALL never stall.

Reset
REQ-019 ResetL=0 SHALL immediately, independent of Clock, clear ReadData and every storage word to 0.
REQ-020 While ResetL=0, writes and reads SHALL be ignored.
REQ-021 After ResetL deasserts, the first active Clock edge SHALL operate normally.
REQ-022 Reset asserted mid-operation SHALL abort any pending access, with no partial update surviving.

Structure
REQ-023 Package data_memory_pkg SHALL hold the DATA_WIDTH, ADDR_WIDTH and DEPTH defaults, plus INDEX_WIDTH = log2(DEPTH).
REQ-024 The storage array with its write port SHALL be one sub-module, data_memory_bank.
- The top level SHALL contain the index decode and the falling-edge ReadData register.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- Reset, then read addresses 0x00 and 0xFF -> ReadData = 0 for both.
- Write 0x14<-0, 0x3c<-0xffff0000, 0x32<-0xaaaaffff, 0x33<-0x5555ff00, 0x0c<-40, then read each one -> each returns its own value, so 0x32 and 0x33 do not interfere.
- Write 0x20<-0, then 0x20<-16435934, then read 0x20 -> 16435934.
- MemoryRead=1 and MemoryWrite=1 with Address 0x05 and WriteData 0x1234 -> ReadData = 0x1234 at the same cycle's falling edge.
- Write 0x0c<-40, then write Address 0x10c<-7 (DEPTH=256) -> read 0x0c returns 7 (aliasing).
- Assert ResetL low between a rising and a falling edge after writing 0x08<-50 -> ReadData = 0 immediately, and a later read of 0x08 returns 0.
